// File: rtl/expand_key_sequencer_if.sv
// Feistel launch/result handshake and SRAM write port used by the
// bcrypt key-expansion sequencer.
interface expand_key_sequencer_if;
    logic        fe_start;
    logic [31:0] fe_L;
    logic [31:0] fe_R;
    logic [63:0] fe_result;
    logic        fe_done;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_cs_l;
    logic        wr_we_l;

    modport master (
        output fe_start,
        output fe_L,
        output fe_R,
        input  fe_result,
        input  fe_done,
        output wr_addr,
        output wr_data,
        output wr_cs_l,
        output wr_we_l
    );

    modport slave (
        input  fe_start,
        input  fe_L,
        input  fe_R,
        output fe_result,
        output fe_done,
        input  wr_addr,
        input  wr_data,
        input  wr_cs_l,
        input  wr_we_l
    );
endinterface

// File: rtl/expand_key_sequencer.sv
// Blowfish ExpandKey/ExpandState encrypt-and-replace sequencer:
// 521 feistel launches, each result written back to P then S.
module expand_key_sequencer #(
    parameter logic [11:0] P_ARRAY_OFFSET = 12'd4000,
    parameter logic [11:0] S_BOX_OFFSET   = 12'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          go,
    input  logic                          use_salt,
    input  logic [127:0]                  salt,
    expand_key_sequencer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic [9:0]                    pair_idx
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] WAIT_F = 3'd2;
    localparam logic [2:0] WR_HI  = 3'd3;
    localparam logic [2:0] WR_LO  = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    localparam logic [9:0] P_PAIRS   = 10'd9;
    localparam logic [9:0] LAST_PAIR = 10'd520;

    logic [2:0]  state;
    logic [63:0] block;
    logic        sh;
    logic        salt_en;

    logic [9:0]  s_idx;
    logic [11:0] base;

    logic [63:0] launch_blk;
    logic        launch_sh;
    logic        launch_en;
    logic [63:0] salt_half;
    logic [63:0] launch_x;

    always_comb begin
        s_idx = pair_idx - P_PAIRS;
        if (pair_idx < P_PAIRS) begin
            base = P_ARRAY_OFFSET + {1'b0, pair_idx, 1'b0};
        end else begin
            base = S_BOX_OFFSET + {1'b0, s_idx, 1'b0};
        end
    end

    // fe_L/fe_R are loaded on the edge that enters LAUNCH so they are
    // already valid while fe_start is high; from IDLE the block, salt
    // select and salt enable are the values being loaded by go.
    always_comb begin
        launch_blk = (state == IDLE) ? 64'd0 : block;
        launch_sh  = (state == IDLE) ? 1'b0 : sh;
        launch_en  = (state == IDLE) ? use_salt : salt_en;
        salt_half  = launch_sh ? salt[63:0] : salt[127:64];
        launch_x   = launch_blk ^ (launch_en ? salt_half : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            block       <= 64'd0;
            sh          <= 1'b0;
            salt_en     <= 1'b0;
            pair_idx    <= 10'd0;
            bus.fe_L    <= 32'd0;
            bus.fe_R    <= 32'd0;
            bus.wr_addr <= 12'd0;
            bus.wr_data <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        block    <= 64'd0;
                        sh       <= 1'b0;
                        salt_en  <= use_salt;
                        pair_idx <= 10'd0;
                        bus.fe_L <= launch_x[63:32];
                        bus.fe_R <= launch_x[31:0];
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_F;
                end
                WAIT_F: begin
                    if (bus.fe_done) begin
                        block       <= bus.fe_result;
                        sh          <= ~sh;
                        bus.wr_addr <= base;
                        bus.wr_data <= bus.fe_result[63:32];
                        state       <= WR_HI;
                    end
                end
                WR_HI: begin
                    bus.wr_addr <= base + 12'd1;
                    bus.wr_data <= block[31:0];
                    state       <= WR_LO;
                end
                WR_LO: begin
                    if (pair_idx == LAST_PAIR) begin
                        state <= FINISH;
                    end else begin
                        pair_idx <= pair_idx + 10'd1;
                        bus.fe_L <= launch_x[63:32];
                        bus.fe_R <= launch_x[31:0];
                        state    <= LAUNCH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fe_start = (state == LAUNCH);
    assign bus.wr_cs_l  = !((state == WR_HI) || (state == WR_LO));
    assign bus.wr_we_l  = !((state == WR_HI) || (state == WR_LO));
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);

endmodule

// File: tb/tb_expand_key_sequencer.sv
// Bench for expand_key_sequencer: feistel responder, SRAM monitor and
// a pair-level reference model of one ExpandKey sweep.
module tb_expand_key_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         go;
    logic         use_salt;
    logic [127:0] salt;
    logic         busy;
    logic         done;
    logic [9:0]   pair_idx;

    expand_key_sequencer_if bus ();

    expand_key_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .use_salt (use_salt),
        .salt     (salt),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .pair_idx (pair_idx)
    );

    typedef struct {
        bit           use_salt;
        logic [127:0] salt;
        int           mode;      // 0: {L+1,R+2}, 1: identity
        int           w;         // 0: random 1..40
        bit           hold_go;
        bit           spur;
        bit           fin_go;
        bit           snap_save;
        bit           snap_cmp;
        logic [31:0]  l0, r0, l1, r1;
        logic [31:0]  w0, w1;
        int           cyc;       // -1: not fixed
    } vec_t;

    localparam logic [127:0] SALT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    int checks = 0;
    int errors = 0;

    int w_cfg = 20;
    int mode_cfg = 0;
    bit spur_cfg = 1'b0;

    logic [31:0] mem  [0:4095];
    logic [31:0] snap [0:4095];
    logic [11:0] wa [0:2047];
    logic [31:0] wd [0:2047];
    logic [31:0] la [0:1023];
    logic [31:0] lr [0:1023];
    int nw, ns, nd, nb;

    logic [11:0] ea [0:1041];
    logic [31:0] ed [0:1041];
    logic [31:0] el [0:520];
    logic [31:0] er [0:520];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One sweep at pair granularity: xor salt half, encrypt, store.
    function automatic void build_exp(input bit us, input logic [127:0] s,
                                      input int mode);
        logic [63:0] blk, x, r, half;
        int base;
        blk = 64'd0;
        for (int k = 0; k < 521; k++) begin
            half = (k % 2 == 0) ? s[127:64] : s[63:0];
            x = us ? (blk ^ half) : blk;
            r = (mode == 1) ? x : {x[63:32] + 32'd1, x[31:0] + 32'd2};
            base = (k < 9) ? 4000 + 2 * k : 2 * (k - 9);
            ea[2*k]   = 12'(base);
            ed[2*k]   = r[63:32];
            ea[2*k+1] = 12'(base + 1);
            ed[2*k+1] = r[31:0];
            el[k] = x[63:32];
            er[k] = x[31:0];
            blk = r;
        end
    endfunction

    // Feistel stand-in: fe_done W cycles after fe_start.
    initial begin
        logic [31:0] cl, cr;
        int wl;
        bus.fe_done = 1'b0;
        bus.fe_result = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.fe_done = 1'b0;
            if (bus.fe_start === 1'b1) begin
                cl = bus.fe_L;
                cr = bus.fe_R;
                wl = (w_cfg == 0) ? int'($urandom_range(40, 1)) : w_cfg;
                repeat (wl) begin
                    @(posedge clk);
                    #1;
                end
                bus.fe_done = 1'b1;
                bus.fe_result = (mode_cfg == 1) ? {cl, cr}
                                                : {cl + 32'd1, cr + 32'd2};
                if (spur_cfg) begin
                    @(posedge clk);
                    #1;
                    bus.fe_result = ~bus.fe_result;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        nw = 0; ns = 0; nd = 0; nb = 0;
        forever begin
            @(negedge clk);
            if (bus.wr_cs_l === 1'b0 && bus.wr_we_l === 1'b0) begin
                mem[bus.wr_addr] = bus.wr_data;
                if (nw < 2048) begin
                    wa[nw] = bus.wr_addr;
                    wd[nw] = bus.wr_data;
                end
                nw++;
            end
            if (bus.fe_start === 1'b1) begin
                if (ns < 1024) begin
                    la[ns] = bus.fe_L;
                    lr[ns] = bus.fe_R;
                end
                ns++;
            end
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
        end
    end

    task automatic run_pass(input vec_t v, input string t);
        int cyc;
        bit seen;
        int bad;
        build_exp(v.use_salt, v.salt, v.mode);
        w_cfg = v.w;
        mode_cfg = v.mode;
        spur_cfg = v.spur;
        use_salt = v.use_salt;
        salt = v.salt;
        nw = 0; ns = 0; nd = 0; nb = 0;
        go = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 30000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && !v.hold_go) go = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({t, "_done_seen"}, 64'(seen), 64'd1);
        go = v.fin_go;
        @(posedge clk);
        #1;
        chk({t, "_done_low"}, 64'(done), 64'd0);
        chk({t, "_busy_low"}, 64'(busy), 64'd0);
        chk({t, "_no_relaunch"}, 64'(bus.fe_start), 64'd0);
        if (v.cyc > 0) chk({t, "_done_cycle"}, 64'(cyc), 64'(v.cyc));
        chk({t, "_busy_cycles"}, 64'(nb), 64'(cyc));
        chk({t, "_done_count"}, 64'(nd), 64'd1);
        chk({t, "_starts"}, 64'(ns), 64'd521);
        chk({t, "_writes"}, 64'(nw), 64'd1042);
        chk({t, "_launch0"}, {la[0], lr[0]}, {v.l0, v.r0});
        chk({t, "_launch1"}, {la[1], lr[1]}, {v.l1, v.r1});
        chk({t, "_wr0"}, {20'd0, wa[0], wd[0]}, {20'd0, 12'd4000, v.w0});
        chk({t, "_wr1"}, {20'd0, wa[1], wd[1]}, {20'd0, 12'd4001, v.w1});
        chk({t, "_addr_p8"}, {wa[16], wa[17]}, {12'd4016, 12'd4017});
        chk({t, "_addr_p9"}, {wa[18], wa[19]}, {12'd0, 12'd1});
        chk({t, "_addr_p520"}, {wa[1040], wa[1041]}, {12'd1022, 12'd1023});
        bad = 0;
        for (int i = 0; i < 1042; i++)
            if (i >= nw || wa[i] !== ea[i] || wd[i] !== ed[i]) bad++;
        chk({t, "_write_seq_bad"}, 64'(bad), 64'd0);
        bad = 0;
        for (int k = 0; k < 521; k++)
            if (k >= ns || la[k] !== el[k] || lr[k] !== er[k]) bad++;
        chk({t, "_launch_seq_bad"}, 64'(bad), 64'd0);
        if (v.snap_save)
            for (int i = 0; i < 4096; i++) snap[i] = mem[i];
        if (v.snap_cmp) begin
            bad = 0;
            for (int i = 0; i < 4096; i++)
                if (mem[i] !== snap[i]) bad++;
            chk({t, "_sram_vs_fixed_w"}, 64'(bad), 64'd0);
        end
        if (v.fin_go) begin
            @(posedge clk);
            #1;
            go = 1'b0;
            chk({t, "_restart_start"}, 64'(bus.fe_start), 64'd1);
            chk({t, "_restart_pair"}, 64'(pair_idx), 64'd0);
            chk({t, "_restart_lr"}, {bus.fe_L, bus.fe_R}, 64'd0);
        end
    endtask

    vec_t vecs [8];

    initial begin
        int nw0, ns0;
        bit found;
        vecs[0] = '{0, 128'd0, 0, 20, 0, 0, 0, 0, 0,
                    32'h0, 32'h0, 32'h1, 32'h2, 32'h1, 32'h2, 11984};
        vecs[1] = '{1, SALT, 1, 20, 0, 0, 0, 0, 0,
                    32'h00112233, 32'h44556677, 32'h88888888, 32'h88888888,
                    32'h00112233, 32'h44556677, 11984};
        vecs[2] = '{0, 128'd0, 0, 1, 0, 0, 0, 0, 0,
                    32'h0, 32'h0, 32'h1, 32'h2, 32'h1, 32'h2, 2085};
        vecs[3] = '{1, SALT, 0, 20, 0, 0, 0, 1, 0,
                    32'h00112233, 32'h44556677, 32'h8888888F, 32'h88888886,
                    32'h00112234, 32'h44556679, 11984};
        vecs[4] = '{1, SALT, 0, 0, 0, 1, 0, 0, 1,
                    32'h00112233, 32'h44556677, 32'h8888888F, 32'h88888886,
                    32'h00112234, 32'h44556679, -1};
        vecs[5] = '{0, 128'd0, 1, 3, 1, 0, 0, 0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3127};
        vecs[6] = '{0, 128'd0, 0, 4, 0, 0, 1, 0, 0,
                    32'h0, 32'h0, 32'h1, 32'h2, 32'h1, 32'h2, 3648};
        vecs[7] = '{0, 128'd0, 0, 2, 0, 0, 0, 0, 0,
                    32'h0, 32'h0, 32'h1, 32'h2, 32'h1, 32'h2, 2606};

        reset = 1'b1;
        go = 1'b0;
        use_salt = 1'b0;
        salt = 128'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fe_start", 64'(bus.fe_start), 64'd0);
        chk("rst_fe_lr", {bus.fe_L, bus.fe_R}, 64'd0);
        chk("rst_wr", {20'd0, bus.wr_addr, bus.wr_data}, 64'd0);
        chk("rst_strobes", {62'd0, bus.wr_cs_l, bus.wr_we_l}, 64'd3);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_pair", 64'(pair_idx), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("v%0d", i));

        // vecs[6] left a fresh pass running; reset it in WAIT_F of pair 100.
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(posedge clk);
            #1;
            if (bus.fe_start === 1'b1 && pair_idx == 10'd100) found = 1'b1;
        end
        chk("rst_reach_pair100", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pair", 64'(pair_idx), 64'd0);
        chk("mid_rst_fe_lr", {bus.fe_L, bus.fe_R}, 64'd0);
        chk("mid_rst_wr", {20'd0, bus.wr_addr, bus.wr_data}, 64'd0);
        chk("mid_rst_strobes", {62'd0, bus.wr_cs_l, bus.wr_we_l}, 64'd3);
        nw0 = nw;
        ns0 = ns;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_writes", 64'(nw - nw0), 64'd0);
        chk("post_rst_starts", 64'(ns - ns0), 64'd0);
        chk("post_rst_idle", {62'd0, busy, bus.fe_start}, 64'd0);
        chk("post_rst_pair", 64'(pair_idx), 64'd0);

        run_pass(vecs[7], "v7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
